// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and writeback signals of the iterative mul/div unit.
// The core side is the master; the unit itself is the slave.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [2:0]               op;
    logic [DATA_WIDTH-1:0]    operand_a;
    logic [DATA_WIDTH-1:0]    operand_b;
    logic [ADDRESS_WIDTH-1:0] dest;
    logic                     busy;
    logic                     done;
    logic                     wb_en;
    logic [ADDRESS_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0]    wb_data;

    modport master (
        output start, op, operand_a, operand_b, dest,
        input  busy, done, wb_en, wb_dest, wb_data
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest,
        output busy, done, wb_en, wb_dest, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per clock.
// Signed ops run on magnitudes; the sign is applied as the result is registered.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
    logic [2*W-1:0]           acc_q, acc_d;
    logic [W-1:0]             opd_q, opd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     neg_q, neg_d;
    logic                     rneg_q, rneg_d;
    logic [W-1:0]             res_q, res_d;

    logic         in_sgn_a;
    logic         in_sgn_b;
    logic         in_neg_a;
    logic         in_neg_b;
    logic         in_div0;
    logic [W-1:0] in_mag_a;
    logic [W-1:0] in_mag_b;

    always_comb begin
        in_sgn_a = 1'b0;
        in_sgn_b = 1'b0;
        case (bus.op)
            3'b001, 3'b100, 3'b110: begin
                in_sgn_a = 1'b1;
                in_sgn_b = 1'b1;
            end
            3'b010:  in_sgn_a = 1'b1;
            default: ;
        endcase
        in_neg_a = in_sgn_a & bus.operand_a[W-1];
        in_neg_b = in_sgn_b & bus.operand_b[W-1];
        in_mag_a = in_neg_a ? -bus.operand_a : bus.operand_a;
        in_mag_b = in_neg_b ? -bus.operand_b : bus.operand_b;
        in_div0  = bus.op[2] & (bus.operand_b == '0);
    end

    // acc holds {hi, lo}: product halves for multiply, {rem, quo} for divide
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_step;
    logic [2*W-1:0] step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opd_q};
        mul_step  = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                             : {1'b0, acc_q[2*W-1:1]};
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opd_q};
        div_step  = div_diff[W]
                  ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        step      = op_q[2] ? div_step : mul_step;
    end

    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   result;

    always_comb begin
        prod   = neg_q ? -step : step;
        quo    = neg_q ? -step[W-1:0] : step[W-1:0];
        rem    = rneg_q ? -step[2*W-1:W] : step[2*W-1:W];
        result = '0;
        case (op_q)
            3'b000:                 result = prod[W-1:0];
            3'b001, 3'b010, 3'b011: result = prod[2*W-1:W];
            3'b100, 3'b101:         result = quo;
            default:                result = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dest_d  = dest_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    dest_d = bus.dest;
                    cnt_d  = '0;
                    neg_d  = in_neg_a ^ in_neg_b;
                    rneg_d = in_neg_a;
                    if (in_div0) begin
                        res_d   = bus.op[1] ? bus.operand_a : '1;
                        state_d = DONE;
                    end else if (bus.op[2]) begin
                        acc_d   = {{W{1'b0}}, in_mag_a};
                        opd_d   = in_mag_b;
                        state_d = CALC;
                    end else begin
                        acc_d   = {{W{1'b0}}, in_mag_b};
                        opd_d   = in_mag_a;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = result;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            dest_q  <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.wb_en   = (state_q == DONE) && (dest_q != '0);
    assign bus.wb_dest = dest_q;
    assign bus.wb_data = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for the iterative RV32M mul/div unit.
// Expectations come from constants and a 64-bit reference model.
module tb_muldiv_unit;
    timeunit 1ns;
    timeprecision 1ps;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        int          lat;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    time  t_acc;

    logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                               3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                               32'h5, 32'h5, 32'hFFFFFF00, 32'h80000001};
    logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h2,
                               32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_x  [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                               32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h80000001};

    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        ref_model = '0;
        case (op)
            3'd0: begin p = sa * sb; ref_model = p[31:0];  end
            3'd1: begin p = sa * sb; ref_model = p[63:32]; end
            3'd2: begin p = sa * ub; ref_model = p[63:32]; end
            3'd3: begin p = ua * ub; ref_model = p[63:32]; end
            3'd4: ref_model = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: ref_model = (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
            3'd6: ref_model = (b == 0) ? a : 32'(sa % sb);
            default: ref_model = (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // Call at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d,
                         input logic [31:0] x);
        exp_t e;
        e.data = x;
        e.dest = d;
        e.lat  = (op[2] && b == 0) ? 0 : 32;
        scb.push_back(e);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest      = d;
        bus.start     = 1'b1;
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.start     = 1'b0;
        bus.op        = 3'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest      = 5'($urandom);
    endtask

    task automatic wait_done(input int budget, output bit seen, output int lat);
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = int'(($time - t_acc - 5) / 10);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.done, bus.wb_en} !== 2'b00)
            $display("FAIL reset_done got %b want 00", {bus.done, bus.wb_en});
        else n_pass++;
        n_checks++;
        if (bus.wb_dest !== 5'd0) $display("FAIL reset_wb_dest got %h want 0", bus.wb_dest);
        else n_pass++;
        n_checks++;
        if (bus.wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", bus.wb_data);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_arith();
        logic [2:0]  op;
        logic [31:0] a, b, x;
        logic [4:0]  d;
        bit          seen;
        int          lat;
        exp_t        e;
        for (int i = 0; i < 26; i++) begin
            if (i < 12) begin
                op = d_op[i];
                a  = d_a[i];
                b  = d_b[i];
                d  = 5'(i + 1);
                x  = d_x[i];
            end else begin
                op = 3'($urandom_range(0, 7));
                a  = (i % 5 == 0) ? 32'h80000000 : $urandom;
                if (i % 4 == 0)      b = 32'd0;
                else if (i % 4 == 1) b = 32'($urandom_range(1, 15));
                else                 b = $urandom;
                d  = 5'($urandom_range(0, 31));
                x  = ref_model(op, a, b);
            end
            issue(op, a, b, d, x);
            wait_done(40, seen, lat);
            e = scb.pop_front();
            n_checks++;
            if (!seen) begin
                $display("FAIL arith[%0d] done got none want pulse (op=%0d)", i, op);
                continue;
            end
            n_pass++;
            n_checks++;
            if (lat !== e.lat) $display("FAIL arith[%0d] latency got %0d want %0d", i, lat, e.lat);
            else n_pass++;
            n_checks++;
            if (bus.wb_data !== e.data)
                $display("FAIL arith[%0d] wb_data op=%0d a=%h b=%h got %h want %h",
                         i, op, a, b, bus.wb_data, e.data);
            else n_pass++;
            n_checks++;
            if (bus.wb_dest !== e.dest) $display("FAIL arith[%0d] wb_dest got %h want %h", i, bus.wb_dest, e.dest);
            else n_pass++;
            n_checks++;
            if (bus.wb_en !== (e.dest != 0)) $display("FAIL arith[%0d] wb_en got %b want %b", i, bus.wb_en, e.dest != 0);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.done, bus.busy} !== 2'b00) $display("FAIL arith[%0d] after_done got %b want 00", i, {bus.done, bus.busy});
            else n_pass++;
            n_checks++;
            if (bus.wb_data !== e.data) $display("FAIL arith[%0d] wb_hold got %h want %h", i, bus.wb_data, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_dest();
        bit   seen;
        int   lat;
        exp_t e;
        issue(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);
        wait_done(40, seen, lat);
        e = scb.pop_front();
        n_checks++;
        if (!seen || bus.wb_en !== 1'b0)
            $display("FAIL dest0 wb_en got seen=%b en=%b want seen=1 en=0", seen, bus.wb_en);
        else n_pass++;
        n_checks++;
        if (bus.wb_data !== e.data) $display("FAIL dest0 wb_data got %h want %h", bus.wb_data, e.data);
        else n_pass++;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd5, 32'd12);
        wait_done(40, seen, lat);
        e = scb.pop_front();
        n_checks++;
        if (!seen || bus.wb_en !== 1'b1 || bus.wb_dest !== e.dest)
            $display("FAIL dest5 got seen=%b en=%b dest=%0d want 1 1 %0d", seen, bus.wb_en, bus.wb_dest, e.dest);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_busy();
        bit   seen;
        int   lat;
        exp_t e;
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE);
        repeat (5) @(negedge clk);
        bus.op = 3'd5; bus.operand_a = 32'd5; bus.operand_b = 32'd0; bus.dest = 5'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(40, seen, lat);
        e = scb.pop_front();
        n_checks++;
        if (!seen || lat !== e.lat) $display("FAIL busy_latency got seen=%b lat=%0d want 1 %0d", seen, lat, e.lat);
        else n_pass++;
        n_checks++;
        if (bus.wb_data !== e.data || bus.wb_dest !== e.dest)
            $display("FAIL busy_result got %h/%0d want %h/%0d", bus.wb_data, bus.wb_dest, e.data, e.dest);
        else n_pass++;
        bus.op = 3'd5; bus.operand_b = 32'd0; bus.dest = 5'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL start_in_done got %b want 00", {bus.busy, bus.done});
        else n_pass++;
        n_checks++;
        if (bus.wb_data !== e.data) $display("FAIL start_in_done_hold got %h want %h", bus.wb_data, e.data);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit   seen;
        int   lat;
        int   n_done;
        exp_t e;
        issue(3'd4, 32'd1000, 32'd7, 5'd3, 32'd142);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.wb_en} !== 3'b000)
            $display("FAIL abort_async got %b want 000", {bus.busy, bus.done, bus.wb_en});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        scb.delete();
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.wb_en === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) $display("FAIL abort_no_done got %0d pulses want 0", n_done);
        else n_pass++;
        issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
        wait_done(40, seen, lat);
        e = scb.pop_front();
        n_checks++;
        if (!seen || lat !== e.lat) $display("FAIL after_abort_latency got seen=%b lat=%0d want 1 %0d", seen, lat, e.lat);
        else n_pass++;
        n_checks++;
        if (bus.wb_data !== e.data || bus.wb_en !== 1'b1 || bus.wb_dest !== e.dest)
            $display("FAIL after_abort_result got %h/%b/%0d want %h/1/%0d",
                     bus.wb_data, bus.wb_en, bus.wb_dest, e.data, e.dest);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.op        = 3'd0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        bus.dest      = 5'd0;
        test_reset();
        test_arith();
        test_dest();
        test_busy();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
